// File: rtl/serial_pkg.sv
// Shared types for the byte serializer: frame FSM state encoding and
// small elaboration-time helpers.
package serial_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Counter width that still yields a 1-bit vector when only one value exists.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Upstream byte handshake plus serial-line status, bundled for the serializer.
interface byte_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output in_data, in_valid,
        input  in_ready, tx, busy, done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, tx, busy, done
    );
endinterface

// File: rtl/byte_serializer_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each period; clear restarts the period from zero.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int             CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign expire = en && !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/byte_serializer.sv
// Byte-to-serial framer: start bit, DATA_W data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT clocks; all outputs come straight from flops.
module byte_serializer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    byte_serializer_if.slave  bus
);
    localparam int               IDX_W    = cnt_w(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              accept;
    logic              expire;

    // in_ready is only ever high in IDLE, so it alone qualifies the accept.
    assign accept = (state == IDLE) && bus.in_valid && bus.in_ready;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .en     (state != IDLE),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_idx      <= '0;
            bus.tx       <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.in_ready <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        shreg        <= bus.in_data;
                        state        <= START;
                        bus.tx       <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b0;
                    end
                end
                START: begin
                    if (expire) begin
                        state   <= DATA;
                        bus.tx  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (expire) begin
                        if (bit_idx == LAST_IDX) begin
                            state  <= STOP;
                            bus.tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            bus.tx  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                STOP: begin
                    // The done cycle doubles as the first accept opportunity.
                    if (expire) begin
                        state        <= IDLE;
                        bit_idx      <= '0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboarded bench: two serializers (4 and 1 clocks per bit) checked every
// cycle against a per-cycle expected-line queue built from the frame format.
module tb_byte_serializer;

    localparam int CPB_A = 4;
    localparam int CPB_B = 1;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    byte_serializer_if #(.DATA_W(8)) ia ();
    byte_serializer_if #(.DATA_W(8)) ib ();

    byte_serializer #(.CLKS_PER_BIT(CPB_A), .DATA_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    byte_serializer #(.CLKS_PER_BIT(CPB_B), .DATA_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line state for cycle k (1-based after accept is k+1) of a frame.
    function automatic exp_t frame_ent(input logic [7:0] d, input int cpb, input int k);
        exp_t e;
        int   bi;
        bi     = k / cpb;
        e.tx   = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : d[bi-1];
        e.busy = 1'b1;
        e.done = 1'b0;
        e.rdy  = 1'b0;
        return e;
    endfunction

    localparam exp_t IDLE_E = '{tx: 1'b1, busy: 1'b0, done: 1'b0, rdy: 1'b1};
    localparam exp_t DONE_E = '{tx: 1'b1, busy: 1'b0, done: 1'b1, rdy: 1'b1};

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete();
            chk("a_rst_tx", ia.tx, 1);
            chk("a_rst_busy", ia.busy, 0);
            chk("a_rst_done", ia.done, 0);
            chk("a_rst_rdy", ia.in_ready, 0);
        end else begin
            e = (qa.size() > 0) ? qa.pop_front() : IDLE_E;
            chk("a_tx", ia.tx, e.tx);
            chk("a_busy", ia.busy, e.busy);
            chk("a_done", ia.done, e.done);
            chk("a_rdy", ia.in_ready, e.rdy);
            if (ia.in_valid && e.rdy) begin
                for (int k = 0; k < 10 * CPB_A; k++) qa.push_back(frame_ent(ia.in_data, CPB_A, k));
                qa.push_back(DONE_E);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qb.delete();
            chk("b_rst_tx", ib.tx, 1);
            chk("b_rst_rdy", ib.in_ready, 0);
        end else begin
            e = (qb.size() > 0) ? qb.pop_front() : IDLE_E;
            chk("b_tx", ib.tx, e.tx);
            chk("b_busy", ib.busy, e.busy);
            chk("b_done", ib.done, e.done);
            chk("b_rdy", ib.in_ready, e.rdy);
            if (ib.in_valid && e.rdy) begin
                for (int k = 0; k < 10 * CPB_B; k++) qb.push_back(frame_ent(ib.in_data, CPB_B, k));
                qb.push_back(DONE_E);
            end
        end
    end

    task automatic wait_idle();
        bool_loop: begin
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                if (qa.size() == 0 && qb.size() == 0 && !ia.busy && !ib.busy) disable bool_loop;
            end
            chk("idle_timeout", 0, 1);
        end
    endtask

    // Counts cycles after an accept edge until done is seen (bounded).
    task automatic done_lat(input logic use_b, input string tag, input int exp);
        int n;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if ((use_b ? ib.done : ia.done) && n == 0) n = i;
            if (n != 0) break;
        end
        chk(tag, n, exp);
    endtask

    initial begin
        int n;
        ia.in_valid = 1'b0;
        ia.in_data  = '0;
        ib.in_valid = 1'b0;
        ib.in_data  = '0;

        // reset and release
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", ia.tx, 1);
        chk("rst_rdy", ia.in_ready, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_rdy", ia.in_ready, 1);

        // single byte, done latency
        @(posedge clk); #1;
        ia.in_valid = 1'b1;
        ia.in_data  = 8'hA5;
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        done_lat(1'b0, "a5_done_lat", 41);
        wait_idle();

        // back-to-back: second byte taken in the done cycle
        @(posedge clk); #1;
        ia.in_valid = 1'b1;
        ia.in_data  = 8'h00;
        @(posedge clk); #1;
        ia.in_data  = 8'hFF;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ia.in_ready) begin n = i; break; end
        end
        chk("b2b_gap", n, 41);
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        wait_idle();

        // reset during data bit 3
        @(posedge clk); #1;
        ia.in_valid = 1'b1;
        ia.in_data  = 8'h00;
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1 chk("mid_tx_lo", ia.tx, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_tx", ia.tx, 1);
        chk("mid_rst_busy", ia.busy, 0);
        chk("mid_rst_done", ia.done, 0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        ia.in_valid = 1'b1;
        ia.in_data  = 8'h3C;
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        done_lat(1'b0, "3c_done_lat", 41);
        wait_idle();

        // in_data churn while busy
        @(posedge clk); #1;
        ia.in_valid = 1'b1;
        ia.in_data  = 8'h5A;
        @(posedge clk); #1;
        repeat (30) begin
            ia.in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        ia.in_valid = 1'b0;
        wait_idle();

        // one clock per bit
        @(posedge clk); #1;
        ib.in_valid = 1'b1;
        ib.in_data  = 8'h80;
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        done_lat(1'b1, "b80_done_lat", 11);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
